// File: rtl/control_uart_fsm_if.sv
// Bus between the UART control FSM and its peripheral/user side.
// The FSM uses the master modport and the environment uses the slave modport.
interface control_uart_fsm_if;
   logic [31:0] salida_perif_UART_i;
   logic [7:0]  sw_i;
   logic        inicio_i;
   logic        enviar_dato;
   logic        wr_o;
   logic        reg_sel_o;
   logic [31:0] entrada_perif_UART_o;
   logic [7:0]  dato_recibido_o;

   modport master (
      input  salida_perif_UART_i,
      input  sw_i,
      input  inicio_i,
      input  enviar_dato,
      output wr_o,
      output reg_sel_o,
      output entrada_perif_UART_o,
      output dato_recibido_o
   );

   modport slave (
      output salida_perif_UART_i,
      output sw_i,
      output inicio_i,
      output enviar_dato,
      input  wr_o,
      input  reg_sel_o,
      input  entrada_perif_UART_o,
      input  dato_recibido_o
   );
endinterface

// File: rtl/control_uart_fsm.sv
// UART polling controller: sends a byte on an enviar_dato rising edge and reads
// received bytes when the peripheral flags RX data.
//
// state   | meaning
// IDLE    | disabled, waiting for inicio_i
// POLL    | watching for a TX request or the RX-available flag
// WR_DATA | write tx byte into the data register
// WR_CTRL | write 1 to the control register to start transmission
// WAIT_TX | wait for the peripheral busy bit to clear
// RD_DATA | read data register; capture received byte
// CLR_RX  | write 0 to the control register to clear the RX flag
module control_uart_fsm (
   input logic                 clk_i,
   input logic                 reset_i,
   control_uart_fsm_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      POLL    = 3'd1,
      WR_DATA = 3'd2,
      WR_CTRL = 3'd3,
      WAIT_TX = 3'd4,
      RD_DATA = 3'd5,
      CLR_RX  = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_enviar_q;
   logic [7:0]  r_tx;
   logic [7:0]  r_dato;
   logic        w_edge;
   logic        w_tx_load;
   logic        w_wr;
   logic        w_sel;
   logic [31:0] w_entrada;
   logic        w_unused_salida;

   assign w_edge          = bus.enviar_dato & ~r_enviar_q;
   assign w_unused_salida = ^bus.salida_perif_UART_i[31:8];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state    <= IDLE;
         r_enviar_q <= 1'b0;
         r_tx       <= 8'h00;
         r_dato     <= 8'h00;
      end else begin
         r_state    <= w_next;
         r_enviar_q <= bus.enviar_dato;
         if (w_tx_load)
            r_tx <= bus.sw_i;
         if (r_state == RD_DATA)
            r_dato <= bus.salida_perif_UART_i[7:0];
      end
   end

   always_comb begin
      w_next    = r_state;
      w_tx_load = 1'b0;
      w_wr      = 1'b0;
      w_sel     = 1'b0;
      w_entrada = 32'h0000_0000;
      case (r_state)
         IDLE: begin
            if (bus.inicio_i)
               w_next = POLL;
         end
         POLL: begin
            // TX request wins over a pending RX byte
            if (!bus.inicio_i) begin
               w_next = IDLE;
            end else if (w_edge) begin
               w_next    = WR_DATA;
               w_tx_load = 1'b1;
            end else if (bus.salida_perif_UART_i[1]) begin
               w_next = RD_DATA;
            end
         end
         WR_DATA: begin
            w_wr      = 1'b1;
            w_sel     = 1'b1;
            w_entrada = {24'h00_0000, r_tx};
            w_next    = WR_CTRL;
         end
         WR_CTRL: begin
            w_wr      = 1'b1;
            w_entrada = 32'h0000_0001;
            w_next    = WAIT_TX;
         end
         WAIT_TX: begin
            if (!bus.salida_perif_UART_i[0])
               w_next = POLL;
         end
         RD_DATA: begin
            w_sel  = 1'b1;
            w_next = CLR_RX;
         end
         CLR_RX: begin
            w_wr   = 1'b1;
            w_next = POLL;
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.wr_o                 = w_wr;
   assign bus.reg_sel_o            = w_sel;
   assign bus.entrada_perif_UART_o = w_entrada;
   assign bus.dato_recibido_o      = r_dato;

endmodule

// File: tb/tb_control_uart_fsm.sv
// Directed bench for control_uart_fsm: expected bus outputs are queued as each
// step is driven and compared on the following falling edge.
module tb_control_uart_fsm;

   typedef logic [41:0] obs_t;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   obs_t sb_q[$];

   control_uart_fsm_if bus ();

   control_uart_fsm dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus.master)
   );

   always #5 clk_i = ~clk_i;

   function automatic obs_t ex(logic wr, logic sel, logic [31:0] ent, logic [7:0] dato);
      return {wr, sel, ent, dato};
   endfunction

   task automatic check_now(string tag);
      obs_t exp_v;
      obs_t got;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s observed=no_expectation expected=queued_value", tag);
      end else begin
         exp_v = sb_q.pop_front();
         got   = {bus.wr_o, bus.reg_sel_o, bus.entrada_perif_UART_o, bus.dato_recibido_o};
         assert (got === exp_v) else begin
            failures++;
            $error("FAIL %s observed wr/sel/entrada/dato=%h expected=%h", tag, got, exp_v);
         end
      end
   endtask

   task automatic step(string tag, logic ini, logic env, logic [31:0] sal, logic [7:0] sw, obs_t e);
      bus.inicio_i            = ini;
      bus.enviar_dato         = env;
      bus.salida_perif_UART_i = sal;
      bus.sw_i                = sw;
      sb_q.push_back(e);
      @(posedge clk_i);
      @(negedge clk_i);
      check_now(tag);
   endtask

   initial begin
      bus.inicio_i            = 1'b0;
      bus.enviar_dato         = 1'b0;
      bus.salida_perif_UART_i = 32'h0;
      bus.sw_i                = 8'h00;

      // reset held across edges
      @(negedge clk_i);
      @(negedge clk_i);
      sb_q.push_back(ex(0, 0, 32'h0, 8'h00));
      check_now("rst_hold");
      reset_i = 1'b0;

      for (int i = 0; i < 5; i++)
         step("idle", 0, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));

      // basic transmit; inicio drop mid-sequence must not abort
      step("to_poll",   1, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));
      step("tx_data",   1, 1, 32'h0, 8'hAF, ex(1, 1, 32'h0000_00AF, 8'h00));
      step("tx_ctrl",   0, 0, 32'h0, 8'h00, ex(1, 0, 32'h0000_0001, 8'h00));
      step("tx_wait",   0, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));
      step("tx_done",   0, 0, 32'h2, 8'h00, ex(0, 0, 32'h0, 8'h00));
      step("poll_idle", 0, 0, 32'h2, 8'h00, ex(0, 0, 32'h0, 8'h00));
      step("idle_norx", 0, 0, 32'h2, 8'h00, ex(0, 0, 32'h0, 8'h00));
      step("to_poll2",  1, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));

      // busy held: stays in WAIT_TX (bit1 also set so leaving early shows a read)
      step("tx2_data", 1, 1, 32'h0, 8'h3C, ex(1, 1, 32'h0000_003C, 8'h00));
      step("tx2_ctrl", 1, 0, 32'h3, 8'h00, ex(1, 0, 32'h0000_0001, 8'h00));
      for (int i = 0; i < 5; i++)
         step("wait_busy", 1, (i % 2 == 0), 32'h3, 8'h55, ex(0, 0, 32'h0, 8'h00));
      step("wait_exit", 1, 1, 32'h0, 8'h55, ex(0, 0, 32'h0, 8'h00));
      step("no_queue",  1, 1, 32'h0, 8'h55, ex(0, 0, 32'h0, 8'h00));
      step("no_queue2", 1, 0, 32'h0, 8'h55, ex(0, 0, 32'h0, 8'h00));

      // receive
      step("rx_read",  1, 0, 32'h2,  8'h00, ex(0, 1, 32'h0, 8'h00));
      step("rx_clr",   1, 0, 32'h5A, 8'h00, ex(1, 0, 32'h0, 8'h5A));
      step("rx_poll",  1, 0, 32'h0,  8'h00, ex(0, 0, 32'h0, 8'h5A));
      step("rx_hold",  1, 0, 32'h0,  8'h00, ex(0, 0, 32'h0, 8'h5A));

      // enviar_dato held high: one transmission only
      step("hold_data", 1, 1, 32'h0, 8'h11, ex(1, 1, 32'h0000_0011, 8'h5A));
      step("hold_ctrl", 1, 1, 32'h0, 8'h22, ex(1, 0, 32'h0000_0001, 8'h5A));
      step("hold_wait", 1, 1, 32'h0, 8'h22, ex(0, 0, 32'h0, 8'h5A));
      for (int i = 0; i < 7; i++)
         step("hold_single", 1, 1, 32'h0, 8'h22, ex(0, 0, 32'h0, 8'h5A));
      step("hold_release", 1, 0, 32'h0, 8'h22, ex(0, 0, 32'h0, 8'h5A));

      // simultaneous TX edge and RX flag: TX first, then read
      step("pri_data", 1, 1, 32'h2,  8'hC3, ex(1, 1, 32'h0000_00C3, 8'h5A));
      step("pri_ctrl", 1, 0, 32'h2,  8'h00, ex(1, 0, 32'h0000_0001, 8'h5A));
      step("pri_wait", 1, 0, 32'h2,  8'h00, ex(0, 0, 32'h0, 8'h5A));
      step("pri_poll", 1, 0, 32'h2,  8'h00, ex(0, 0, 32'h0, 8'h5A));
      step("pri_read", 1, 0, 32'h2,  8'h00, ex(0, 1, 32'h0, 8'h5A));
      step("pri_clr",  1, 0, 32'h77, 8'h00, ex(1, 0, 32'h0, 8'h77));
      step("pri_end",  1, 0, 32'h0,  8'h00, ex(0, 0, 32'h0, 8'h77));

      // async reset in the middle of a write strobe
      step("rst_pre", 1, 1, 32'h0, 8'h99, ex(1, 1, 32'h0000_0099, 8'h77));
      bus.enviar_dato = 1'b0;
      #2 reset_i = 1'b1;
      sb_q.push_back(ex(0, 0, 32'h0, 8'h00));
      #1 check_now("rst_async_wr");
      step("rst_held", 1, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));
      reset_i = 1'b0;
      step("post_rst_poll", 1, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));

      // async reset during WAIT_TX, then no further strobe
      step("rw_data", 1, 1, 32'h0, 8'h42, ex(1, 1, 32'h0000_0042, 8'h00));
      step("rw_ctrl", 1, 0, 32'h1, 8'h00, ex(1, 0, 32'h0000_0001, 8'h00));
      step("rw_wait", 1, 0, 32'h1, 8'h00, ex(0, 0, 32'h0, 8'h00));
      #2 reset_i = 1'b1;
      sb_q.push_back(ex(0, 0, 32'h0, 8'h00));
      #1 check_now("rst_async_wait");
      step("rst_wait_held", 0, 0, 32'h0, 8'h00, ex(0, 0, 32'h0, 8'h00));
      reset_i = 1'b0;
      step("rst_wait_idle", 0, 0, 32'h2, 8'h00, ex(0, 0, 32'h0, 8'h00));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
